// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: issues reads to a 1-cycle BRAM, buffers words in a prefetch FIFO
// and presents {instr, pc, pc+4} to decode. Define RV_FETCH_MISALIGN_EN to trap misaligned redirects.
module rv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_r_addr,
    output logic            imem_r_enb,
    input  logic [XLEN-1:0] imem_r_dat,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus_4,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [XLEN-1:0] r_fetchPc;
    logic [XLEN-1:0] r_respPc;
    logic            r_inflight;

    logic [XLEN-1:0] r_dataMem [DEPTH];
    logic [XLEN-1:0] r_pcMem   [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [CW-1:0]   w_occupancy;
    logic [XLEN-1:0] w_redirectTarget;
    logic            w_redirectMisaligned;

`ifdef RV_FETCH_MISALIGN_EN
    assign w_redirectMisaligned = |redirect_pc[1:0];
    assign w_redirectTarget     = redirect_pc;
`else
    assign w_redirectMisaligned = 1'b0;
    assign w_redirectTarget     = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
`endif

    // Occupancy counts the in-flight read so a response always has a free slot to land in.
    assign w_occupancy = r_count + CW'(r_inflight);
    assign w_empty     = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        if (redirect_valid) begin
            w_nextState = w_redirectMisaligned ? ST_HALT : ST_RUN;
        end
        if ((r_state == ST_RUN) && !rst && !redirect_valid && (w_occupancy < CW'(DEPTH))) begin
            w_issue = 1'b1;
        end
    end

    assign imem_r_enb  = w_issue;
    assign imem_r_addr = r_fetchPc;

    // A response arriving on a redirect edge belongs to the old stream and is simply dropped.
    assign w_push = r_inflight && !redirect_valid && !rst;
    assign w_pop  = !w_empty && instr_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc  <= RESET_PC;
            r_respPc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_valid) begin
                r_fetchPc <= w_redirectTarget;
            end else if (w_issue) begin
                r_fetchPc <= r_fetchPc + XLEN'(4);
                r_respPc  <= r_fetchPc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dataMem[r_wrPtr] <= imem_r_dat;
            r_pcMem[r_wrPtr]   <= r_respPc;
        end
    end

    // Show-ahead head; forced to zero when empty so the idle bus is clean.
    assign instr_valid     = !w_empty;
    assign instr_data      = instr_valid ? r_dataMem[r_rdPtr] : '0;
    assign instr_pc        = instr_valid ? r_pcMem[r_rdPtr] : '0;
    assign instr_pc_plus_4 = instr_valid ? (r_pcMem[r_rdPtr] + XLEN'(4)) : '0;

`ifdef RV_FETCH_MISALIGN_EN
    logic            r_misalignErr;
    logic [XLEN-1:0] r_misalignPc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalignErr <= 1'b0;
            r_misalignPc  <= '0;
        end else if (redirect_valid) begin
            if (w_redirectMisaligned) begin
                r_misalignErr <= 1'b1;
                r_misalignPc  <= redirect_pc;
            end else begin
                r_misalignErr <= 1'b0;
            end
        end
    end

    assign misalign_err = r_misalignErr;
    assign misalign_pc  = r_misalignPc;
`else
    assign misalign_err = 1'b0;
    assign misalign_pc  = '0;
`endif

endmodule

// File: doc/rv_fetch_queue.md
Name: rv_fetch_queue

Overview:
Parametrised instruction-fetch front end, the successor to the single-cycle PC + instruction BRAM pairing.
- Drives a synchronous-read instruction memory (1-cycle read latency, bram32-compatible).
- Buffers fetched words in a prefetch FIFO and hands {instr, pc, pc+4} to decode over a valid/ready handshake.
- Redirect port (branch/jump) flushes the queue and discards in-flight responses, so decode can stall without losing fetches.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
imem_r_addr  out  XLEN  instruction memory read address (word aligned)
imem_r_enb  out  1  read enable; memory samples addr/enb on clk edge, imem_r_dat valid the following cycle
imem_r_dat  in  XLEN  read data
redirect_valid  in  1  load new PC, flush queue
redirect_pc  in  XLEN  target PC
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head
instr_data  out  XLEN  head instruction
instr_pc  out  XLEN  head PC
instr_pc_plus_4  out  XLEN  head PC + 4
misalign_err  out  1  misaligned redirect trapped (feature only)
misalign_pc  out  XLEN  offending redirect target (feature only)

Behaviour:
Reset (rst high at an edge):
- fetch_pc <= RESET_PC; FIFO empty; in-flight flag cleared; FSM -> RUN.
- Outputs: instr_valid 0; instr_data, instr_pc, instr_pc_plus_4 0; misalign_err 0; misalign_pc 0.
- imem_r_enb is 0 while rst high.
- rst mid-operation drops everything, including the in-flight response.

FSM states: RUN and HALT. HALT is reachable only with the feature enabled.

Issue (combinational):
- imem_r_enb = RUN & !rst & !redirect_valid & (count + inflight < DEPTH).
- imem_r_addr = fetch_pc.
- On an issuing edge: inflight <= 1, resp_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
- PC arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0000_0000.

Response:
- The cycle after issue, imem_r_dat is written into the FIFO at the next edge, together with resp_pc.
- inflight clears at that edge unless a new read issues at the same edge.
- Throughput: one word per cycle sustained.

Latency:
- Request issued in cycle N -> instr_valid high in cycle N+2.
- After rst falls, first instr_valid is 2 cycles later, with instr_pc = RESET_PC.

Dequeue:
- Pop when instr_valid & instr_ready.
- Push and pop in the same cycle are legal, and count is unchanged.
- Outputs come straight from the head entry (show-ahead); they hold stable while instr_valid & !instr_ready.

Full / empty:
- No read is issued when count + inflight = DEPTH, so there is never overflow.
- instr_valid = 0 when empty; instr_ready is ignored when empty.

Pointers: log2(DEPTH)-bit read/write pointers wrap naturally; count is log2(DEPTH)+1 bits.

Redirect (has priority over everything except rst):
- Edge with redirect_valid: FIFO cleared, any pop in that cycle ignored, fetch_pc <= redirect_pc.
- The response of a read issued in the previous cycle is discarded (epoch/kill bit) and never enters the FIFO.
- No issue in the redirect cycle; first fetch of the target occurs the next cycle; instr_valid for the target 2 cycles after the redirect edge.
- Back-to-back redirects: the last one wins.
- Without the feature, redirect_pc[1:0] is forced to 00.

Optional Feature:
RV_FETCH_MISALIGN_EN
- Defined: a redirect with redirect_pc[1:0] != 00 flushes as normal, then moves to HALT.
  - misalign_err <= 1 and misalign_pc <= redirect_pc (sticky).
  - In HALT, no issue and instr_valid 0.
  - A later aligned redirect returns to RUN and clears misalign_err; rst also clears it.
- Undefined: misalign_err and misalign_pc are tied to 0; the low two bits are cleared and fetching continues.

Test Plan:
1. Reset release, memory word i = 0x1000_0000 + i, instr_ready = 1 -> instr_valid rises 2 cycles after rst falls; instr_pc 0x0, 0x4, 0x8... one per cycle; data 0x1000_0000, 0x1000_0001...
2. instr_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 entries held, imem_r_enb low once count + inflight = 4, head stable at pc 0x0; releasing ready drains 0x0..0xC with no gap or duplicate.
3. redirect_valid with redirect_pc = 0x200 while a read is in flight and the queue holds 3 entries -> flushed; stale word never appears; next instr_pc = 0x200, 2 cycles after the redirect edge.
4. Redirect to 0xFFFF_FFF8 -> instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; instr_pc_plus_4 of the last entry = 0x4.
5. Redirect to 0x102: with RV_FETCH_MISALIGN_EN, misalign_err = 1, misalign_pc = 0x102, no fetch; then redirect to 0x100 resumes. Without the macro, fetch proceeds at 0x100.
6. rst asserted mid-stream with a full queue -> next cycle instr_valid 0; after release, fetching restarts at RESET_PC.
